// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : FSM states (FETCH issues a memory request, ISSUE presents
//                      the fetched instruction until it is consumed)
//   NOP_WORD         : instruction word presented after reset
//   DEFAULT_RESET_PC : default PC loaded on reset
//   align4()         : clears the two low address bits of a target
package instr_fetch_unit_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch unit (purely combinational).
//   jump, jump_target       : jump redirect, highest priority
//   branch_taken, branch_target : taken-branch redirect
//   pc_plus4                : fall-through address
//   next_pc                 : selected address with bits [1:0] cleared
module pc_next_sel
    import instr_fetch_unit_pkg::*;
(
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = branch_target;
        // Targets come straight from the datapath; never let a misaligned
        // address reach the PC.
        next_pc = align4(next_pc);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the MIPS core. Holds the PC, fetches one
// instruction at a time over a req/ack memory handshake (any number of wait
// states) and presents it with PC+4 until downstream consumes it. The
// jump/branch decision for the presented instruction selects the next PC.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_addr/req/rdata/ack   : instruction memory handshake
//   stall                     : downstream not ready, hold the current instruction
//   jump/jump_target          : jump redirect for the issuing instruction
//   branch_taken/branch_target: branch redirect for the issuing instruction
//   instr, pc_plus4, instr_valid : issued instruction (registered)
//   instr_count               : instructions consumed since reset (wraps)
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ack,
    input  logic             stall,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      instr,
    output logic [31:0]      pc_plus4,
    output logic             instr_valid,
    output logic [CNT_W-1:0] instr_count
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;

    pc_next_sel u_pc_next_sel (
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    // Request and address decode straight from state/pc so memory can answer
    // in the same cycle the request appears.
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!stall)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= align4(RESET_PC);
            instr       <= NOP_WORD;
            pc_plus4    <= 32'h0;
            instr_valid <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // rdata is only meaningful in the ack cycle.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_plus4    <= pc + 32'd4;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Redirect inputs belong to the issuing instruction, so
                    // they only matter on the consume cycle.
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
